rc_charge_sequencer: RTL and testbench
======================================

Name: rc_charge_sequencer

Overview:
- Digital sequencer for the schematic RC measurement cell: battery source charging a capacitor through a resistor.
- Drives two analog switches: discharge short across the capacitor, and battery-to-resistor charge path.
- Runs discharge → dead time → charge, timing charge until an external comparator trips, then reports the cycle count.
- Sits between the digital control plane and the analog cell's switch and comparator nets.

Parameters:
- CNT_W, 16, width of charge counter and result.
- DISCHARGE_CYCLES, 64, clocks sw_discharge is held high; legal range 1..2^16-1.
- TIMEOUT, 65535, charge count at which measurement is abandoned; must be ≤ 2^CNT_W-1 and ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a measurement; sampled only in IDLE.
- cmp_in  in  1  asynchronous comparator output; 1 = capacitor voltage above threshold.
- sw_discharge  out  1  closes capacitor short.
- sw_charge  out  1  closes battery→resistor→capacitor path.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: valid result.
- timeout  out  1  one-cycle pulse: TIMEOUT reached without trip.
- err  out  1  one-cycle pulse: comparator still high after discharge.
- result  out  CNT_W  last measured charge count.

Behaviour:
- One clock and one reset: clk, asynchronous active-high rst. All outputs are registered.
- Reset values: state IDLE, all switches 0, busy 0, done 0, timeout 0, err 0, result 0, counters 0, synchronizer flops 0.
- cmp_in passes through a 2-flop synchronizer to give cmp_s. The 2-cycle latency is included in result and is not compensated.
- IDLE:
  - Switches open.
  - start=1 → DISCH, load the discharge counter with DISCHARGE_CYCLES.
- DISCH:
  - sw_discharge=1.
  - Counter decrements each cycle. At 1, leave DISCH after exactly DISCHARGE_CYCLES cycles of sw_discharge=1.
  - On leaving: if cmp_s=1 → IDLE and err pulses in the first IDLE cycle. Otherwise → DEAD.
- DEAD:
  - Exactly 1 cycle with both switches 0, so the switches break before make.
  - → CHARGE, charge counter cleared to 0.
- CHARGE:
  - sw_charge=1.
  - Each cycle: if cmp_s=1, latch result ← count, → IDLE, done pulses in the first IDLE cycle.
  - Else if count = TIMEOUT, result ← TIMEOUT, → IDLE, timeout pulses.
  - Else count ← count+1.
  - The cmp_s check has priority over the TIMEOUT check in the same cycle.
- sw_discharge and sw_charge are never 1 in the same cycle, nor in consecutive cycles.
- start while busy is ignored and not queued. start in the IDLE cycle where done, timeout or err is high is accepted.
- result holds its value until the next done or timeout. err leaves result unchanged.
- rst mid-measurement opens both switches immediately (asynchronously) and returns to IDLE with no pulse.

Optional Feature:
- Macro RC_CMP_FILTER_EN.
- Defined: trip requires cmp_s=1 on 3 consecutive CHARGE cycles. result = count at the third sample. The filter history clears on entering CHARGE. The DISCH err check also uses the filtered value: 3 consecutive highs at the end of DISCH, otherwise no err.
- Undefined: single-sample cmp_s as described above.

Test Plan:
Settings for all scenarios unless noted: DISCHARGE_CYCLES=4, TIMEOUT=100, filter off.
- Reset then start=1 for one cycle, cmp_in rises 10 cycles after CHARGE entry → sw_discharge high exactly 4 cycles, 1 dead cycle, done pulse, result=12 (10 + 2 synchronizer cycles), busy drops the same cycle done rises.
- cmp_in held 0 → sw_charge high for 101 cycles, timeout pulse, result=100, no done.
- cmp_in held 1 throughout → after 4 discharge cycles, err pulse, sw_charge never asserted, result unchanged from prior value.
- start pulsed during DISCH and CHARGE → ignored; exactly one done. start held high continuously → back-to-back measurements, each preceded by 4 discharge cycles.
- rst asserted mid-CHARGE (count≈50) → sw_charge 0 without waiting for a clock edge, busy=0, result=0, no pulses; next start runs a normal measurement.
- RC_CMP_FILTER_EN: 1-cycle and 2-cycle cmp_in glitches at count 20 → no trip. A steady rise afterwards trips with result = steady count + 2 (synchronizer) + 2 (filter).

Source files
------------

// File: rtl/rc_charge_sequencer.sv
// Discharge / dead-time / charge sequencer for the RC measurement cell; times the charge until the comparator trips.
// Optional macro RC_CMP_FILTER_EN: a trip needs three consecutive synchronized comparator highs.
module rc_charge_sequencer #(
    parameter int CNT_W            = 16,
    parameter int DISCHARGE_CYCLES = 64,
    parameter int TIMEOUT          = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sw_discharge,
    output logic             sw_charge,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err,
    output logic [CNT_W-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_DISCH, S_DEAD, S_CHARGE} state_t;

    localparam logic [15:0]      DIS_LOAD  = 16'(DISCHARGE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic [15:0]      dis_cnt, dis_cnt_nx;
    logic [CNT_W-1:0] chg_cnt, chg_cnt_nx;
    logic [CNT_W-1:0] result_nx;
    logic             done_nx, timeout_nx, err_nx;
    logic             cmp_meta, cmp_s;
    logic             trip;

    // cmp_in is asynchronous to clk; its two-cycle latency is deliberately left in the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

`ifdef RC_CMP_FILTER_EN
    logic [1:0] hist;

    // History only spans DISCH or CHARGE; it is empty on entry to either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist <= 2'b00;
        else if (state == S_IDLE || state == S_DEAD)
            hist <= 2'b00;
        else
            hist <= {hist[0], cmp_s};
    end

    assign trip = cmp_s & (hist == 2'b11);
`else
    assign trip = cmp_s;
`endif

    always_comb begin
        state_nx   = state;
        dis_cnt_nx = dis_cnt;
        chg_cnt_nx = chg_cnt;
        result_nx  = result;
        done_nx    = 1'b0;
        timeout_nx = 1'b0;
        err_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_DISCH;
                    dis_cnt_nx = DIS_LOAD;
                end
            end
            S_DISCH: begin
                if (dis_cnt == 16'd1) begin
                    if (trip) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = S_DEAD;
                    end
                end else begin
                    dis_cnt_nx = dis_cnt - 16'd1;
                end
            end
            S_DEAD: begin
                state_nx   = S_CHARGE;
                chg_cnt_nx = '0;
            end
            S_CHARGE: begin
                // A trip wins over the timeout when both land on the same count.
                if (trip) begin
                    result_nx = chg_cnt;
                    done_nx   = 1'b1;
                    state_nx  = S_IDLE;
                end else if (chg_cnt == TIMEOUT_V) begin
                    result_nx  = TIMEOUT_V;
                    timeout_nx = 1'b1;
                    state_nx   = S_IDLE;
                end else begin
                    chg_cnt_nx = chg_cnt + CNT_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so switches follow the state with no glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            dis_cnt      <= '0;
            chg_cnt      <= '0;
            result       <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            err          <= 1'b0;
            sw_discharge <= 1'b0;
            sw_charge    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            dis_cnt      <= dis_cnt_nx;
            chg_cnt      <= chg_cnt_nx;
            result       <= result_nx;
            done         <= done_nx;
            timeout      <= timeout_nx;
            err          <= err_nx;
            sw_discharge <= (state_nx == S_DISCH);
            sw_charge    <= (state_nx == S_CHARGE);
            busy         <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_rc_charge_sequencer.sv
// Bench for rc_charge_sequencer: directed and random comparator waveforms against a count-domain reference model.
// Honours RC_CMP_FILTER_EN for the expected trip rule.
module tb_rc_charge_sequencer;

    localparam int CNT_W = 16;
    localparam int DIS   = 4;
    localparam int TMO   = 100;
`ifdef RC_CMP_FILTER_EN
    localparam int FILT_N = 3;
`else
    localparam int FILT_N = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cmp_in = 1'b0;
    logic             sw_discharge, sw_charge, busy, done, timeout, err;
    logic [CNT_W-1:0] result;

    int               n_cmp = 0;
    int               n_err = 0;
    int               last_res = 0;
    logic             wave [0:TMO];
    logic [CNT_W-1:0] exp_q[$];

    rc_charge_sequencer #(
        .CNT_W(CNT_W),
        .DISCHARGE_CYCLES(DIS),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cmp_in(cmp_in),
        .sw_discharge(sw_discharge),
        .sw_charge(sw_charge),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .err(err),
        .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // wave[c] is cmp_in during the charge cycle whose count is c; the comparator
    // seen by the sequencer at count c is wave[c-2], and a trip needs FILT_N in a row.
    function automatic void ref_model(output bit tripped, output int res);
        int run;
        run = 0;
        tripped = 1'b0;
        res = TMO;
        for (int c = 0; c <= TMO; c++) begin
            logic s;
            s = (c >= 2) ? wave[c-2] : 1'b0;
            run = s ? run + 1 : 0;
            if (run >= FILT_N) begin
                tripped = 1'b1;
                res = c;
                return;
            end
        end
    endfunction

    task automatic fill_wave(input int rise, input int g1, input int g2);
        for (int c = 0; c <= TMO; c++)
            wave[c] = (c >= rise) || (c == g1) || (c == g2);
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic measure(input string tag, input bit poke, input bit hold, input bit cmp_hi);
        bit   exp_trip;
        int   exp_res;
        int   n_dis, n_dead, n_chg, guard, bad_sw, extra;
        logic prev_dis;
        exp_trip = 1'b0;
        exp_res = 0;
        if (!cmp_hi) begin
            ref_model(exp_trip, exp_res);
            exp_q.push_back(CNT_W'(exp_res));
        end
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n_dis = 0; n_dead = 0; n_chg = 0; guard = 0; bad_sw = 0; extra = 0;
        prev_dis = 1'b0;
        while (busy && guard < 400) begin
            if (sw_discharge && sw_charge) bad_sw++;
            if (sw_charge && prev_dis) bad_sw++;
            if (done || timeout || err) extra++;
            if (sw_discharge) n_dis++;
            else if (sw_charge) begin
                cmp_in = cmp_hi ? 1'b1 : wave[n_chg];
                n_chg++;
            end else n_dead++;
            if (poke && !hold) start = (n_dis == 2) || (n_chg == 5);
            prev_dis = sw_discharge;
            @(posedge clk); #1;
            guard++;
        end
        start = hold;
        if (!cmp_hi) cmp_in = 1'b0;
        check({tag, " finished_in_budget"}, 32'(guard < 400), 1);
        check({tag, " discharge_cycles"}, n_dis, DIS);
        check({tag, " switch_overlap"}, bad_sw, 0);
        check({tag, " pulse_while_busy"}, extra, 0);
        if (cmp_hi) begin
            check({tag, " err"}, 32'(err), 1);
            check({tag, " done"}, 32'(done | timeout), 0);
            check({tag, " charge_cycles"}, n_chg, 0);
            check({tag, " result_kept"}, 32'(result), last_res);
        end else begin
            logic [CNT_W-1:0] exp_r;
            exp_r = exp_q.pop_front();
            check({tag, " dead_cycles"}, n_dead, 1);
            check({tag, " charge_cycles"}, n_chg, 32'(exp_r) + 1);
            check({tag, " done"}, 32'(done), 32'(exp_trip));
            check({tag, " timeout"}, 32'(timeout), 32'(!exp_trip));
            check({tag, " err"}, 32'(err), 0);
            check({tag, " result"}, 32'(result), 32'(exp_r));
            last_res = exp_res;
        end
    endtask

    initial begin
        int guard;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset sw_discharge", 32'(sw_discharge), 0);
        check("reset sw_charge", 32'(sw_charge), 0);
        check("reset busy", 32'(busy), 0);
        check("reset pulses", 32'({done, timeout, err}), 0);
        check("reset result", 32'(result), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle busy", 32'(busy), 0);

        // comparator rises at count 10
        fill_wave(10, -1, -1);
        measure("rise10", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rise10 done_one_cycle", 32'(done), 0);

        // never trips
        fill_wave(TMO + 10, -1, -1);
        measure("timeout", 1'b0, 1'b0, 1'b0);

        // comparator stuck high across discharge
        cmp_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        measure("err", 1'b0, 1'b0, 1'b1);
        cmp_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // start pulses while busy are ignored
        fill_wave(12, -1, -1);
        measure("poke", 1'b1, 1'b0, 1'b0);
        guard = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy || done) guard++;
        end
        check("poke no_second_run", guard, 0);

        // start held high gives back-to-back runs
        fill_wave(7, -1, -1);
        measure("hold_a", 1'b0, 1'b1, 1'b0);
        fill_wave(20, 3, -1);
        measure("hold_b", 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;

        // glitches at 20 (1 cycle) and 30..31 (2 cycles), steady from 50
        fill_wave(50, 20, -1);
        wave[30] = 1'b1;
        wave[31] = 1'b1;
        measure("glitch", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            fill_wave(int'($urandom_range(0, TMO + 5)), int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)));
            measure("random", 1'b0, 1'b0, 1'b0);
        end

        // asynchronous reset mid-charge
        fill_wave(TMO + 10, -1, -1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!sw_charge && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("abort reached_charge", 32'(sw_charge), 1);
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort sw_charge", 32'(sw_charge), 0);
        check("abort busy", 32'(busy), 0);
        check("abort result", 32'(result), 0);
        check("abort pulses", 32'({done, timeout, err}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = 0;
        @(posedge clk); #1;
        check("abort still_quiet", 32'({done, timeout, err, busy}), 0);
        fill_wave(33, -1, -1);
        measure("after_abort", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
